// File: rtl/pwl_activation_piped.sv
// Programmable piecewise-linear activation: segment select, multiply, offset/saturate, symmetry.
// Result 3 edges after acceptance; one out_valid&~out_ready stall freezes every stage together.
module pwl_activation_piped #(
  parameter int DW   = 16,
  parameter int FRAC = 10,
  parameter int SEGS = 8,
  localparam int SB  = $clog2(SEGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data_out,
  input  logic          cfg_we,
  input  logic [SB+1:0] cfg_addr,
  input  logic [DW-1:0] cfg_wdata
);

  localparam logic signed [DW-1:0]   SMAX   = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]   SMIN   = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [2*DW:0]   SAT_HI = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW:0]   SAT_LO = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [2*DW:0]   ONE    = {{(2*DW){1'b0}}, 1'b1} << FRAC;

  function automatic logic signed [DW-1:0] f_sat(input logic signed [2*DW:0] v);
    if (v > SAT_HI)      f_sat = SMAX;
    else if (v < SAT_LO) f_sat = SMIN;
    else                 f_sat = v[DW-1:0];
  endfunction

  logic signed [DW-1:0] r_bp     [SEGS];
  logic signed [DW-1:0] r_slope  [SEGS];
  logic signed [DW-1:0] r_offset [SEGS];
  logic [1:0]           r_mode;

  logic [1:0]    w_region;
  logic [SB-1:0] w_idx;
  logic          w_adv;

  assign w_region = cfg_addr[SB+1:SB];
  assign w_idx    = cfg_addr[SB-1:0];
  assign w_adv    = ~(out_valid & ~out_ready);
  assign in_ready = w_adv;

  // r_bp[SEGS-1] has no write path and stays zero; the segment count never reads it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SEGS; i++) begin
        r_bp[i]     <= '0;
        r_slope[i]  <= '0;
        r_offset[i] <= '0;
      end
      r_mode <= '0;
    end else if (cfg_we) begin
      case (w_region)
        2'd0: if (w_idx != SB'(SEGS-1)) r_bp[w_idx] <= cfg_wdata;
        2'd1: r_slope[w_idx]  <= cfg_wdata;
        2'd2: r_offset[w_idx] <= cfg_wdata;
        default: if (w_idx == '0) r_mode <= cfg_wdata[1:0];
      endcase
    end
  end

  logic signed [DW-1:0] w_x;
  logic signed [DW-1:0] w_u;
  logic [SB-1:0]        w_seg;

  assign w_x = data_in;

  always_comb begin
    w_u = w_x;
    if ((r_mode == 2'd1 || r_mode == 2'd2) && w_x[DW-1])
      w_u = (w_x == SMIN) ? SMAX : -w_x;
    w_seg = '0;
    for (int i = 0; i < SEGS-1; i++)
      if (r_bp[i] <= w_u) w_seg = w_seg + 1'b1;
  end

  logic                   r_s1_vld, r_s1_neg;
  logic signed [DW-1:0]   r_s1_u, r_s1_slope, r_s1_off;
  logic [1:0]             r_s1_mode;
  logic                   r_s2_vld, r_s2_neg;
  logic signed [2*DW-1:0] r_s2_p;
  logic signed [DW-1:0]   r_s2_off;
  logic [1:0]             r_s2_mode;
  logic                   r_s3_vld, r_s3_neg;
  logic signed [DW-1:0]   r_s3_r;
  logic [1:0]             r_s3_mode;

  logic signed [2*DW-1:0] w_prod;
  logic signed [2*DW:0]   w_sum;
  logic signed [2*DW:0]   w_r_ext;
  logic signed [DW-1:0]   w_y;

  assign w_prod  = $signed({{DW{r_s1_slope[DW-1]}}, r_s1_slope}) *
                   $signed({{DW{r_s1_u[DW-1]}}, r_s1_u});
  assign w_sum   = $signed({r_s2_p[2*DW-1], r_s2_p}) +
                   $signed({{(DW+1){r_s2_off[DW-1]}}, r_s2_off});
  assign w_r_ext = $signed({{(DW+1){r_s3_r[DW-1]}}, r_s3_r});

  // Mode 3 is unassigned and falls through to the plain (mode 0) result.
  always_comb begin
    w_y = r_s3_r;
    if (r_s3_neg) begin
      case (r_s3_mode)
        2'd1:    w_y = f_sat(-w_r_ext);
        2'd2:    w_y = f_sat(ONE - w_r_ext);
        default: w_y = r_s3_r;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_neg   <= 1'b0;
      r_s1_u     <= '0;
      r_s1_slope <= '0;
      r_s1_off   <= '0;
      r_s1_mode  <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_neg   <= 1'b0;
      r_s2_p     <= '0;
      r_s2_off   <= '0;
      r_s2_mode  <= '0;
      r_s3_vld   <= 1'b0;
      r_s3_neg   <= 1'b0;
      r_s3_r     <= '0;
      r_s3_mode  <= '0;
      out_valid  <= 1'b0;
      data_out   <= '0;
    end else if (w_adv) begin
      r_s1_vld   <= in_valid;
      r_s1_neg   <= w_x[DW-1];
      r_s1_u     <= w_u;
      r_s1_slope <= r_slope[w_seg];
      r_s1_off   <= r_offset[w_seg];
      r_s1_mode  <= r_mode;
      r_s2_vld   <= r_s1_vld;
      r_s2_neg   <= r_s1_neg;
      r_s2_p     <= w_prod >>> FRAC;
      r_s2_off   <= r_s1_off;
      r_s2_mode  <= r_s1_mode;
      r_s3_vld   <= r_s2_vld;
      r_s3_neg   <= r_s2_neg;
      r_s3_r     <= f_sat(w_sum);
      r_s3_mode  <= r_s2_mode;
      out_valid  <= r_s3_vld;
      data_out   <= w_y;
    end
  end

endmodule

// File: tb/tb_pwl_activation_piped.sv
// Scoreboard bench for pwl_activation_piped: directed table programs, symmetry, stalls, reset.
module tb_pwl_activation_piped;

  localparam int DW = 16, FRAC = 10, SEGS = 8;

  logic        clk = 1'b0, reset = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1, cfg_we = 1'b0;
  logic [15:0] data_in = '0, cfg_wdata = '0;
  logic [4:0]  cfg_addr = '0;
  logic        in_ready, out_valid;
  logic [15:0] data_out;

  pwl_activation_piped #(.DW(DW), .FRAC(FRAC), .SEGS(SEGS)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  typedef struct { logic [15:0] dat; int acc; bit lat; } exp_t;
  exp_t q[$];
  exp_t e;

  int sh_bp[SEGS], sh_sl[SEGS], sh_of[SEGS], sh_mode = 0;

  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic logic [15:0] model(input logic [15:0] xb);
    int x, u, seg, r, y;
    longint p;
    x = int'($signed(xb));
    u = x;
    if ((sh_mode == 1 || sh_mode == 2) && x < 0) u = (x == -32768) ? 32767 : -x;
    seg = 0;
    for (int i = 0; i < SEGS-1; i++) if (sh_bp[i] <= u) seg++;
    p = (longint'(sh_sl[seg]) * longint'(u)) >>> FRAC;
    r = sat16(p + longint'(sh_of[seg]));
    y = r;
    if (x < 0 && sh_mode == 1) y = sat16(-longint'(r));
    if (x < 0 && sh_mode == 2) y = sat16(longint'(1 << FRAC) - longint'(r));
    return y[15:0];
  endfunction

  task automatic cfg_set(input int rg, input int ix, input logic [15:0] d);
    cfg_we = 1'b1;
    cfg_addr = {rg[1:0], ix[2:0]};
    cfg_wdata = d;
  endtask

  task automatic cfg_commit();
    int ix, d;
    ix = int'(cfg_addr[2:0]);
    d = int'($signed(cfg_wdata));
    case (cfg_addr[4:3])
      2'd0: if (ix != SEGS-1) sh_bp[ix] = d;
      2'd1: sh_sl[ix] = d;
      2'd2: sh_of[ix] = d;
      default: if (ix == 0) sh_mode = int'(cfg_wdata[1:0]);
    endcase
    cfg_we = 1'b0;
  endtask

  task automatic cfg_wr(input int rg, input int ix, input logic [15:0] d);
    cfg_set(rg, ix, d);
    @(posedge clk); #1;
    cfg_commit();
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] exp, input bit lat);
    bit acc;
    int n = 0;
    in_valid = 1'b1;
    data_in = x;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 50) begin check("accept_bound", n, 50); break; end
    end
    if (acc) q.push_back('{exp, cyc, lat});
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin @(posedge clk); n++; end
    #1;
    check("drain", q.size(), 0);
  endtask

  task automatic setup();
    for (int i = 0; i < SEGS-1; i++) cfg_wr(0, i, 16'((i-3) * 16'h0400));
    cfg_wr(0, SEGS-1, 16'h8000);
    for (int i = 0; i < SEGS; i++) begin
      cfg_wr(1, i, 16'h0000);
      cfg_wr(2, i, 16'(i * 16'h0100));
    end
    cfg_wr(3, 0, 16'h0000);
    cfg_wr(3, 1, 16'h0002);
  endtask

  logic [15:0] hold_dat;
  bit hold = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_vld", out_valid, 1);
        check("stall_dat", data_out, hold_dat);
      end
      if (out_valid && !out_ready) check("stall_rdy", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious", out_valid, 0);
        else begin
          e = q.pop_front();
          check("data", data_out, e.dat);
          if (e.lat) check("latency", cyc - e.acc, 3);
        end
      end
      hold = out_valid && !out_ready;
      hold_dat = data_out;
    end
  end

  logic [15:0] xs [6] = '{16'hF800, 16'hFC00, 16'h0000, 16'h0200, 16'h0C00, 16'h7000};

  initial begin
    repeat (2) @(posedge clk); #1;
    check("rst_ovld", out_valid, 0);
    check("rst_dout", data_out, 0);
    check("rst_irdy", in_ready, 1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Slope path on the all-zero reset tables (every sample lands in segment 0).
    cfg_wr(1, 0, 16'h0200);
    send(16'hF000, 16'hF800, 1);
    cfg_wr(1, 0, 16'h0001);
    send(16'hFFFF, 16'hFFFF, 1);
    drain();

    setup();
    send(16'h0000, 16'h0400, 1);
    send(16'hF400, 16'h0100, 1);
    send(16'hF000, 16'h0000, 1);
    send(16'h7FFF, 16'h0700, 1);
    drain();

    cfg_wr(1, 7, 16'h7FFF);
    cfg_wr(2, 7, 16'h7FFF);
    send(16'h7FFF, 16'h7FFF, 0);
    cfg_wr(1, 0, 16'h7FFF);
    send(16'h8000, 16'h8000, 0);
    drain();

    setup();
    cfg_wr(3, 0, 16'h0002);
    send(16'hFC00, 16'hFF00, 0);
    cfg_wr(3, 0, 16'h0001);
    send(16'hFC00, 16'hFB00, 0);
    send(16'h8000, 16'hF900, 0);
    drain();

    cfg_wr(3, 0, 16'h0000);
    for (int i = 0; i < SEGS; i++) cfg_wr(1, i, 16'(i * 16'h0080));
    fork
      begin
        for (int i = 0; i < 6; i++) send(xs[i], model(xs[i]), 0);
      end
      begin
        repeat (3) @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    setup();
    cfg_set(2, 4, 16'h0123);
    send(16'h0000, 16'h0400, 0);
    cfg_commit();
    send(16'h0000, 16'h0123, 0);
    drain();

    for (int i = 0; i < 3; i++) send(16'h0000, model(16'h0000), 0);
    @(posedge clk); #1;
    check("pre_rst_ovld", out_valid, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_ovld", out_valid, 0);
    check("mid_rst_dout", data_out, 0);
    q.delete();
    for (int i = 0; i < SEGS; i++) begin sh_bp[i] = 0; sh_sl[i] = 0; sh_of[i] = 0; end
    sh_mode = 0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (8) @(posedge clk); #1;
    send(16'h0000, model(16'h0000), 0);
    send(16'h8000, model(16'h8000), 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pwl_activation_piped.md
Name: pwl_activation_piped

Overview:
- Parametrised, programmable piecewise-linear (PWL) activation unit for signed fixed-point datapaths.
- Generalises the fixed 8-segment pipelined sigmoid in four ways:
  - parametrised width, fraction bits and segment count;
  - run-time programmable breakpoint/slope/offset tables;
  - symmetry modes, so one half-table can serve sigmoid or tanh;
  - valid/ready handshake with backpressure.
- Sits between a neuron accumulator and the next layer's input buffer.

Parameters:
- DW, 16: data width, two's complement, signed.
- FRAC, 10: fractional bits. 1.0 = 1<<FRAC (0x0400 at default).
- SEGS, 8: number of segments. Power of 2, ≥2. SB = log2(SEGS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  unit can accept a sample.
- data_in  in  DW  signed input x.
- out_valid  out  1  data_out valid.
- out_ready  in  1  downstream accepts the output.
- data_out  out  DW  signed result y.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  SB+2  [SB+1:SB] = region, [SB-1:0] = index.
- cfg_wdata  in  DW  configuration write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, data_out=0; all stage valid bits cleared.
  - All bp/slope/offset entries =0; mode=0.
  - A reset mid-stream drops in-flight samples; no partial output.
- Config regions:
  - 0 = breakpoint bp[idx]. Only idx 0..SEGS-2 are stored; writes to idx SEGS-1 are ignored.
  - 1 = slope[idx].
  - 2 = offset[idx].
  - 3 = control: idx 0, wdata[1:0] = mode. Other indices are ignored.
- Config timing:
  - cfg writes are accepted on any cycle and ignore the handshake.
  - A sample accepted on the same edge as a write uses the old table.
  - Samples accepted on later edges use the new table.
  - Table values are captured into the pipeline at S1, so in-flight samples are unaffected by later writes.
- Handshake:
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - in_ready = ~(out_valid & ~out_ready). The whole pipeline stalls as one unit.
  - data_out and out_valid hold stable while stalled.
  - Throughput is 1 sample/cycle. Bubbles propagate through the stages.
- Latency: a sample accepted at edge k produces out_valid=1 after edge k+3, assuming no stall.
- S1 (segment select):
  - Form the magnitude input u:
    - mode 0: u = x;
    - mode 1 or 2: u = |x|, with x = -2^(DW-1) saturating to 2^(DW-1)-1.
  - seg = number of breakpoints with bp[i] ≤ u (signed compare), range 0..SEGS-1.
  - This definition holds even if the breakpoints are not ascending.
  - Register u, slope[seg], offset[seg], neg = x<0, and mode.
- S2 (multiply):
  - p = slope × u as a 2·DW-bit signed product.
  - Arithmetic shift right by FRAC, truncating toward −inf. Register the result.
- S3 (offset, saturate, symmetry):
  - r = sat_DW(p + offset), offset sign-extended.
  - Then:
    - mode 0, or x ≥ 0: y = r;
    - mode 1 with neg: y = sat(−r);
    - mode 2 with neg: y = sat(ONE − r), where ONE = 1<<FRAC;
    - mode 3: behaves as mode 0.
  - Register y into data_out and set out_valid.
- Saturation: clamp to [−2^(DW−1), 2^(DW−1)−1]. There is no wrap-around anywhere in the datapath.

Test Plan:
Common setup for tests 1, 3, 4 and 6 (defaults DW=16, FRAC=10, SEGS=8): program bp[i] = (i−3)·0x0400 for i=0..6, all slopes = 0, offset[i] = i·0x0100.
1. Mode 0, segment select:
   - x=0x0000 → 0x0400.
   - x=0xF400 (−3.0) → 0x0100.
   - x=0xF000 → 0x0000.
   - x=0x7FFF → 0x0700.
   - Each result appears 3 cycles after acceptance.
2. Slope path:
   - Program slope[0]=0x0200, offset[0]=0.
   - x=0xF000 (−4.0) → 0xF800.
   - Program slope[0]=0x0001, offset[0]=0: x=0xFFFF → 0xFFFF (floor of a negative value).
3. Saturation:
   - Program slope[7]=0x7FFF, offset[7]=0x7FFF.
   - x=0x7FFF → 0x7FFF.
   - Program slope[0]=0x7FFF: x=0x8000 → 0x8000.
4. Symmetry modes:
   - mode=2, x=0xFC00 → 0x0400−0x0500 = 0xFF00.
   - mode=1, x=0xFC00 → 0xFB00.
   - mode=1, x=0x8000 → u saturates to 0x7FFF → 0xF900.
5. Backpressure:
   - Stream 6 back-to-back samples; hold out_ready=0 for 4 cycles mid-stream.
   - Expect: in_ready=0 during the stall, data_out stable, all 6 outputs delivered in order with no loss or duplication.
6. Config and reset timing:
   - Write offset[4]=0x0123 on the same edge that x=0 is accepted → output 0x0400. The next sample x=0 → 0x0123.
   - Assert reset with 3 samples in flight → out_valid=0 immediately, tables cleared, no stale outputs after release.
